// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// wb_req_t is the writeback request format used by the pipeline and this block.
package rf_wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] idx);
    logic [NREGS-1:0] vec;
    vec      = {NREGS{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO for long-latency writeback results.
// not_full is registered from the next-state count, so it never sees a same-cycle pop.
module rf_wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  wb_req_t                 push_data,
  input  logic                    pop,
  output wb_req_t                 head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    not_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t        mem_q [DEPTH];
  wb_req_t        mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           not_full_q, not_full_d;

  // Next-state storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    not_full_d = (count_d < CW'(DEPTH));
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      not_full_q <= 1'b1;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      not_full_q <= not_full_d;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign not_full = not_full_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB has fixed priority, buffered
// long-latency results fill idle slots; also tracks busy registers and starvation.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_AW-1:0] mdu_waddr,
  input  logic [DATA_W-1:0] mdu_wdata,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_waddr,
  output logic [NREGS-1:0]  busy_vec,
  output logic              stall_req,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  wb_req_t          push_req_s;
  wb_req_t          head_s;
  wb_req_t          wr_sel_s;
  logic [CW-1:0]    fifo_count_s;
  logic             fifo_not_full_s;
  logic             fifo_nonempty_s;
  logic             pipe_eff_s;
  logic             head_vld_s;
  logic             push_s;
  logic             pop_s;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             stall_q, stall_d;

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_req_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .not_full  (fifo_not_full_s)
  );

  // Write-port select; r0 writes from either source are dropped without using the slot.
  always_comb begin
    wr_sel_s        = '0;
    pop_s           = 1'b0;
    pipe_eff_s      = pipe_we && (pipe_waddr != REG_AW'(0));
    fifo_nonempty_s = (fifo_count_s != CW'(0));
    head_vld_s      = !reset && fifo_nonempty_s && head_s.we;
    push_s          = mdu_valid && fifo_not_full_s && (mdu_waddr != REG_AW'(0));
    push_req_s      = '{we: 1'b1, waddr: mdu_waddr, wdata: mdu_wdata};
    if (pipe_eff_s) begin
      wr_sel_s = '{we: 1'b1, waddr: pipe_waddr, wdata: pipe_wdata};
      pop_s    = 1'b0;
    end else if (head_vld_s) begin
      wr_sel_s = head_s;
      pop_s    = 1'b1;
    end else begin
      wr_sel_s = '0;
      pop_s    = 1'b0;
    end
  end

  // Busy scoreboard and starvation counter next state; a same-index set beats the clear.
  always_comb begin
    busy_d = busy_q;
    if (pop_s) begin
      busy_d = busy_d & ~reg_onehot(head_s.waddr);
    end else begin
      busy_d = busy_q;
    end
    if (iss_valid && (iss_waddr != REG_AW'(0))) begin
      busy_d = busy_d | reg_onehot(iss_waddr);
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;

    starve_d = '0;
    if (fifo_nonempty_s && !pop_s) begin
      if (starve_q == STARVE_MAX) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end else begin
      starve_d = '0;
    end
    stall_d = (starve_d == STARVE_MAX);
  end

  // Scoreboard, starvation and stall registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign rf_we     = wr_sel_s.we;
  assign rf_waddr  = wr_sel_s.waddr;
  assign rf_wdata  = wr_sel_s.wdata;
  assign mdu_ready = fifo_not_full_s;
  assign busy_vec  = busy_q;
  assign stall_req = stall_q;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (rf_we/rf_waddr/rf_wdata) between two writeback sources.
  - The in-order pipeline WB stage has fixed priority and no backpressure.
  - The multi-cycle unit (mul/div/load-miss) uses a valid/ready handshake and is buffered in a small FIFO.
- Keeps a 32-bit busy scoreboard of registers reserved by long-latency ops, used by decode for interlock.
- Raises a stall request when a buffered result has been starved too long.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 4, cycles a FIFO head may wait before stall_req is raised (>=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous active-high reset.
- pipe_we  in  1  pipeline WB write enable.
- pipe_waddr  in  5  pipeline WB destination.
- pipe_wdata  in  32  pipeline WB data.
- mdu_valid  in  1  long-latency result valid.
- mdu_ready  out  1  FIFO can accept a result.
- mdu_waddr  in  5  long-latency result destination.
- mdu_wdata  in  32  long-latency result data.
- iss_valid  in  1  decode issues a long-latency op this cycle.
- iss_waddr  in  5  destination being reserved.
- busy_vec  out  32  scoreboard; bit i=1 means reg i has a pending long-latency write.
- stall_req  out  1  pipeline must bubble WB.
- rf_we  out  1  to regfile write port.
- rf_waddr  out  5  to regfile write port.
- rf_wdata  out  32  to regfile write port.

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset values:
  - FIFO empty; busy_vec=0; starve counter=0; stall_req=0; mdu_ready=1.
  - rf_we=0 while pipe_we=0.
  - Reset mid-operation discards buffered results and all reservations.
- Write-port select (combinational, zero added latency):
  - pipe_eff = pipe_we && pipe_waddr!=0. Writes to r0 are dropped and the slot is free.
  - If pipe_eff: rf_we=1, rf_waddr/rf_wdata taken from pipe_*.
  - Else if FIFO not empty: rf_we=1, rf_waddr/rf_wdata taken from the FIFO head; the head pops at the clock edge.
  - Else: rf_we=0, rf_waddr/rf_wdata=0.
- FIFO:
  - mdu_ready = (count<DEPTH). It is registered-state based and does not depend on the same-cycle pop.
  - Push when mdu_valid && mdu_ready. Results with mdu_waddr==0 are not pushed (they are accepted and discarded).
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo DEPTH. Order is strictly FIFO.
- Scoreboard:
  - iss_valid && iss_waddr!=0 sets busy[iss_waddr] at the edge.
  - A FIFO pop clears busy[head.waddr].
  - Set and clear of the same index in the same cycle: set wins.
  - busy_vec[0] is always 0.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and no pop occurs. It clears on pop or when empty.
  - stall_req is registered: it goes to 1 the cycle after the counter reaches STARVE_LIMIT, and to 0 the cycle after the pop.
  - Contract: the pipeline drives pipe_we=0 in any cycle stall_req=1. If it violates this, the pipe write still wins, and no write is ever dropped.
- Illegal cases, checked by bench assertions (no RTL recovery):
  - pipe_eff to a register with busy=1.
  - iss_valid to an already-busy register.
  - mdu result to a non-busy register.

Decomposition:
- Shared package holds:
  - REG_AW=5, DATA_W=32, NREGS=32.
  - A wb_req struct {we, waddr, wdata} used by the pipeline and this block.
- One sub-module: rf_wb_fifo, a synchronous FIFO with push/pop/count and a registered not-full output.
- Arbitration, scoreboard and starvation logic stay in the top.

Test Plan:
- Reset → rf_we=0, busy_vec=0, mdu_ready=1, stall_req=0. Assert reset with 2 FIFO entries held → all cleared next cycle.
- iss r5; two cycles later mdu_valid r5=0xDEADBEEF with pipe_we=0 → rf_we=1, r5=0xDEADBEEF in the following cycle; busy_vec[5] goes 1 then 0.
- pipe_we to r3=0x11 every cycle while an MDU result for r7 is queued → r3 writes every cycle. stall_req rises after STARVE_LIMIT=4 stalled cycles. With pipe bubble next cycle → r7 written, stall_req drops next cycle.
- Push 2 results (r8,r9) back-to-back with pipe busy → mdu_ready=0 at count=2. A third valid is held. Pipe idle → r8 then r9 are written in order, and ready returns.
- pipe_we to r0=0x55 with r4 queued → r4 is written that cycle and r0 is never written. mdu result to r0 is accepted, not written, and no busy change.
- iss r6 in the same cycle the FIFO pops an old r6 → busy_vec[6] stays 1.
